// File: rtl/input_conditioner.sv
// Multi-channel input front end: synchroniser, polarity fix, debounce,
// registered press/release pulses and optional hold-to-repeat per channel.
module input_conditioner #(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 330000,
    parameter logic [CHANNELS-1:0] INVERT          = '0,
    parameter int                  REPEAT_DELAY    = 16500000,
    parameter int                  REPEAT_PERIOD   = 3300000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                changed
);

    localparam int CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW         = $clog2(((REPEAT_MAX > 1) ? REPEAT_MAX : 1) + 1);

    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [TW-1:0] PERIOD_LAST = TW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam bit            REPEAT_ON   = (REPEAT_DELAY != 0);

    // States: IDLE no repeat pending | DELAY waiting for first repeat | RPT periodic repeats
    typedef enum logic [1:0] {IDLE, DELAY, RPT} rep_state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          db_cnt;
        logic                   lvl_q;
        logic                   press_q;
        logic                   rel_q;
        logic                   synced;
        logic                   differ;
        logic                   toggle;
        logic                   rise;
        logic                   fall;
        logic                   rep_fire;
        rep_state_t             state_q;
        rep_state_t             state_d;
        logic [TW-1:0]          tmr_q;
        logic [TW-1:0]          tmr_d;

        assign synced = sync_q[SYNC_STAGES-1];
        assign differ = synced ^ lvl_q;
        assign toggle = differ && (db_cnt == DB_LAST);
        assign rise   = toggle && !lvl_q;
        assign fall   = toggle && lvl_q;

        // A debounced fall or a dropped enable always wins over a timer expiry.
        always_comb begin
            state_d  = state_q;
            tmr_d    = tmr_q;
            rep_fire = 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise && repeat_en[i] && REPEAT_ON) begin
                        state_d = DELAY;
                        tmr_d   = '0;
                    end
                end
                DELAY: begin
                    if (fall || !repeat_en[i]) begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == DELAY_LAST) begin
                        rep_fire = 1'b1;
                        state_d  = RPT;
                        tmr_d    = '0;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                RPT: begin
                    if (fall || !repeat_en[i]) begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == PERIOD_LAST) begin
                        rep_fire = 1'b1;
                        tmr_d    = '0;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q  <= '0;
                db_cnt  <= '0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                state_q <= IDLE;
                tmr_q   <= '0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_in[i] ^ INVERT[i]};
                db_cnt  <= (differ && !toggle) ? db_cnt + CW'(1) : '0;
                lvl_q   <= lvl_q ^ toggle;
                press_q <= rise || rep_fire;
                rel_q   <= fall;
                state_q <= state_d;
                tmr_q   <= tmr_d;
            end
        end

        assign level[i]         = lvl_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;
    end

    assign changed = |(press | release_pulse);

endmodule
